// File: rtl/rgb_pixel_fetch.sv
// Streams a 320x240 RGB frame out of 16-bit SRAM words into a 4-deep show-ahead
// pixel FIFO, fetching 3-word groups (two pixels) only when the FIFO has room.
module rgb_pixel_fetch #(
    parameter int unsigned FRAME_PIXELS = 76800
) (
    input  logic        Clock_50,
    input  logic        Reset,
    input  logic        Start,
    input  logic [17:0] Base_address,
    input  logic [15:0] SRAM_read_data,
    input  logic        Pixel_req,
    output logic [17:0] SRAM_address,
    output logic        SRAM_we_n,
    output logic [7:0]  Pixel_R,
    output logic [7:0]  Pixel_G,
    output logic [7:0]  Pixel_B,
    output logic        Pixel_valid,
    output logic        Busy,
    output logic        Frame_done,
    output logic        Underflow
);

    localparam int unsigned ADDR_W = 18;
    localparam int unsigned CNT_W  = 17;
    localparam int unsigned PIX_W  = 24;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PTR_W  = 2;
    localparam int unsigned OCC_W  = 3;
    localparam int unsigned SUM_W  = 4;

    localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(FRAME_PIXELS - 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FRAME_PIXELS * 3 / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_n;

    // Issue side
    logic [1:0]        grp_ph;
    logic [ADDR_W-1:0] next_addr;
    logic [CNT_W-1:0]  word_cnt;
    logic [OCC_W-1:0]  inflight;

    // Two-stage return tracking: address cycle, then data-valid cycle
    logic              iss_vld;
    logic [1:0]        iss_ph;
    logic              cap_vld;
    logic [1:0]        cap_ph;
    logic [7:0]        hold_r;
    logic [7:0]        hold_g;

    // Pixel FIFO
    logic [PIX_W-1:0]  fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic [CNT_W-1:0]  pix_cnt;

    // Combinational controls
    logic              accept_c;
    logic              room_c;
    logic              start_grp_c;
    logic              issue_c;
    logic              last_word_c;
    logic              frame_end_c;
    logic              pop_c;
    logic              push_c;
    logic [PIX_W-1:0]  push_data_c;
    logic [OCC_W-1:0]  occ_n;
    logic [PTR_W-1:0]  rd_ptr_n;
    logic [PIX_W-1:0]  head_n;

    assign pop_c  = Pixel_req && Pixel_valid;
    // A group reserves space for both of its pixels before the first word goes out
    assign room_c = ({1'b0, occ} + {1'b0, inflight} + SUM_W'(2)) <= SUM_W'(DEPTH);

    // State register
    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (Start)       state_n = S_FETCH;
            S_FETCH: if (last_word_c) state_n = S_DRAIN;
            S_DRAIN: if (frame_end_c) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // FSM control outputs
    always_comb begin
        accept_c    = 1'b0;
        start_grp_c = 1'b0;
        issue_c     = 1'b0;
        last_word_c = 1'b0;
        frame_end_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    accept_c    = 1'b1;
                    start_grp_c = 1'b1;
                    issue_c     = 1'b1;
                end
            end
            S_FETCH: begin
                if (grp_ph == 2'd0) begin
                    if (room_c) begin
                        start_grp_c = 1'b1;
                        issue_c     = 1'b1;
                    end
                end else begin
                    issue_c     = 1'b1;
                    last_word_c = (grp_ph == 2'd2) && (word_cnt == LAST_WORD);
                end
            end
            S_DRAIN: begin
                frame_end_c = pop_c && (pix_cnt == LAST_PIX);
            end
            default: ;
        endcase
    end

    // Address generation and group sequencing
    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            SRAM_address <= '0;
            SRAM_we_n    <= 1'b1;
            next_addr    <= '0;
            word_cnt     <= '0;
            grp_ph       <= 2'd0;
            iss_vld      <= 1'b0;
            iss_ph       <= 2'd0;
            cap_vld      <= 1'b0;
            cap_ph       <= 2'd0;
            inflight     <= '0;
        end else begin
            SRAM_we_n <= 1'b1;
            if (accept_c) begin
                SRAM_address <= Base_address;
                next_addr    <= Base_address + ADDR_W'(1);
                word_cnt     <= CNT_W'(1);
            end else if (issue_c) begin
                SRAM_address <= next_addr;
                next_addr    <= next_addr + ADDR_W'(1);
                word_cnt     <= word_cnt + CNT_W'(1);
            end
            if (start_grp_c) begin
                grp_ph <= 2'd1;
            end else if (issue_c) begin
                grp_ph <= (grp_ph == 2'd2) ? 2'd0 : grp_ph + 2'd1;
            end
            iss_vld  <= issue_c;
            iss_ph   <= grp_ph;
            cap_vld  <= iss_vld;
            cap_ph   <= iss_ph;
            inflight <= inflight + (start_grp_c ? OCC_W'(2) : OCC_W'(0)) - OCC_W'(push_c);
        end
    end

    // Word unpacking: phase 0 holds R/G, phase 1 emits pixel 2k, phase 2 emits 2k+1
    always_comb begin
        push_c = cap_vld && (cap_ph != 2'd0);
        if (cap_ph == 2'd1) begin
            push_data_c = {hold_r, hold_g, SRAM_read_data[15:8]};
        end else begin
            push_data_c = {hold_r, SRAM_read_data};
        end
    end

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            hold_r <= '0;
            hold_g <= '0;
        end else if (cap_vld) begin
            if (cap_ph == 2'd0) begin
                hold_r <= SRAM_read_data[15:8];
                hold_g <= SRAM_read_data[7:0];
            end else if (cap_ph == 2'd1) begin
                hold_r <= SRAM_read_data[7:0];
            end
        end
    end

    // Next head-of-FIFO: a push into an effectively empty FIFO becomes the head directly
    always_comb begin
        occ_n    = occ + OCC_W'(push_c) - OCC_W'(pop_c);
        rd_ptr_n = rd_ptr + PTR_W'(pop_c);
        if (push_c && (occ == OCC_W'(pop_c))) begin
            head_n = push_data_c;
        end else begin
            head_n = fifo_mem[rd_ptr_n];
        end
    end

    always_ff @(posedge Clock_50) begin
        if (push_c) begin
            fifo_mem[wr_ptr] <= push_data_c;
        end
    end

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            Pixel_valid <= 1'b0;
            Pixel_R     <= '0;
            Pixel_G     <= '0;
            Pixel_B     <= '0;
        end else begin
            wr_ptr      <= wr_ptr + PTR_W'(push_c);
            rd_ptr      <= rd_ptr_n;
            occ         <= occ_n;
            Pixel_valid <= (occ_n != '0);
            if (occ_n != '0) begin
                {Pixel_R, Pixel_G, Pixel_B} <= head_n;
            end
        end
    end

    // Frame status
    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            pix_cnt    <= '0;
            Busy       <= 1'b0;
            Frame_done <= 1'b0;
            Underflow  <= 1'b0;
        end else begin
            if (accept_c) begin
                pix_cnt <= '0;
            end else if (pop_c) begin
                pix_cnt <= pix_cnt + CNT_W'(1);
            end
            Busy       <= (state_n != S_IDLE);
            Frame_done <= frame_end_c;
            Underflow  <= Underflow | (Pixel_req & ~Pixel_valid);
        end
    end

endmodule

// File: tb/tb_rgb_pixel_fetch.sv
// Randomized bench for rgb_pixel_fetch: SRAM image model plus an expected pixel
// stream derived directly from the word packing rules, on a reduced frame size.
module tb_rgb_pixel_fetch;

    localparam int unsigned FRAME_PIXELS = 96;
    localparam int unsigned NWORDS       = FRAME_PIXELS * 3 / 2;
    localparam int unsigned BUDGET       = FRAME_PIXELS * 20 + 200;

    logic        Clock_50;
    logic        Reset;
    logic        Start;
    logic [17:0] Base_address;
    logic [15:0] SRAM_read_data;
    logic        Pixel_req;
    logic [17:0] SRAM_address;
    logic        SRAM_we_n;
    logic [7:0]  Pixel_R;
    logic [7:0]  Pixel_G;
    logic [7:0]  Pixel_B;
    logic        Pixel_valid;
    logic        Busy;
    logic        Frame_done;
    logic        Underflow;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic [15:0] sram [262144];

    rgb_pixel_fetch #(.FRAME_PIXELS(FRAME_PIXELS)) dut (
        .Clock_50      (Clock_50),
        .Reset         (Reset),
        .Start         (Start),
        .Base_address  (Base_address),
        .SRAM_read_data(SRAM_read_data),
        .Pixel_req     (Pixel_req),
        .SRAM_address  (SRAM_address),
        .SRAM_we_n     (SRAM_we_n),
        .Pixel_R       (Pixel_R),
        .Pixel_G       (Pixel_G),
        .Pixel_B       (Pixel_B),
        .Pixel_valid   (Pixel_valid),
        .Busy          (Busy),
        .Frame_done    (Frame_done),
        .Underflow     (Underflow)
    );

    initial Clock_50 = 1'b0;
    always #10 Clock_50 = ~Clock_50;

    // SRAM: data for the address held during a cycle appears in the following cycle
    always @(posedge Clock_50) SRAM_read_data <= sram[SRAM_address];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge Clock_50) begin
        if (Frame_done === 1'b1) done_cnt++;
        if (dut.push_c === 1'b1) chk("push_room", 32'(dut.occ < 3'd4), 32'd1);
    end

    // Pixel k of a frame at base: pairs of pixels packed into 3 big-endian words
    function automatic logic [23:0] exp_pix(input logic [17:0] base, input int k);
        logic [17:0] a;
        logic [15:0] w0, w1, w2;
        a  = base + 18'(3 * (k / 2));
        w0 = sram[a];
        w1 = sram[a + 18'd1];
        w2 = sram[a + 18'd2];
        if (k % 2 == 0) return {w0, w1[15:8]};
        return {w1[7:0], w2};
    endfunction

    task automatic step();
        @(posedge Clock_50);
        #1;
    endtask

    task automatic start_frame(input logic [17:0] base);
        Base_address = base;
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    // rnd=1: random pops gated by Pixel_valid plus stray Starts; rnd=0: pop every other cycle
    task automatic consume(input logic [17:0] base, input bit rnd, input int stop_at);
        int  k   = 0;
        int  cyc = 0;
        bit  ph  = 1'b1;
        chk("busy_in_frame", 32'(Busy), 32'd1);
        while (k < stop_at && cyc < BUDGET) begin
            logic req;
            if (rnd) req = ($urandom_range(0, 2) != 0) && Pixel_valid;
            else     req = ph;
            ph = ~ph;
            if (rnd && $urandom_range(0, 15) == 0) begin
                Start = 1'b1;
                Base_address = 18'($urandom);
            end else begin
                Start = 1'b0;
            end
            Pixel_req = req;
            if (req) begin
                if (Pixel_valid) begin
                    chk($sformatf("pix%0d", k), 32'({Pixel_R, Pixel_G, Pixel_B}), 32'(exp_pix(base, k)));
                    k++;
                end else begin
                    chk("valid_at_req", 32'(Pixel_valid), 32'd1);
                end
            end
            step();
            cyc++;
        end
        Pixel_req = 1'b0;
        Start = 1'b0;
        chk("pixels_popped", 32'(k), 32'(stop_at));
        if (stop_at == FRAME_PIXELS) begin
            chk("frame_done_pulse", 32'(Frame_done), 32'd1);
            chk("busy_drop", 32'(Busy), 32'd0);
            step();
            chk("frame_done_clear", 32'(Frame_done), 32'd0);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(Pixel_valid), 32'd0);
        chk({tag, "_rgb"},   32'({Pixel_R, Pixel_G, Pixel_B}), 32'd0);
        chk({tag, "_addr"},  32'(SRAM_address), 32'd0);
        chk({tag, "_we_n"},  32'(SRAM_we_n), 32'd1);
        chk({tag, "_busy"},  32'(Busy), 32'd0);
        chk({tag, "_done"},  32'(Frame_done), 32'd0);
        chk({tag, "_uflow"}, 32'(Underflow), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) sram[i] = 16'($urandom);
        sram[0] = 16'h1122;
        sram[1] = 16'h3344;
        sram[2] = 16'h5566;
        Reset = 1'b1;
        Start = 1'b0;
        Pixel_req = 1'b0;
        Base_address = '0;
        step();
        step();
        Reset = 1'b0;
        chk_reset_outputs("rst");

        // First-pixel latency and packing, Start the cycle after reset
        start_frame(18'd0);
        chk("addr_t1", 32'(SRAM_address), 32'd0);
        chk("busy_t1", 32'(Busy), 32'd1);
        step();
        chk("addr_t2", 32'(SRAM_address), 32'd1);
        chk("valid_t2", 32'(Pixel_valid), 32'd0);
        step();
        chk("valid_t3", 32'(Pixel_valid), 32'd0);
        step();
        chk("valid_t4", 32'(Pixel_valid), 32'd1);
        chk("rgb_t4", 32'({Pixel_R, Pixel_G, Pixel_B}), 32'h112233);

        // No consumer: two groups then a stall at A+5
        for (int i = 0; i < 20; i++) step();
        chk("stall_addr", 32'(SRAM_address), 32'd5);
        chk("stall_valid", 32'(Pixel_valid), 32'd1);
        for (int i = 0; i < 10; i++) step();
        chk("stall_addr_hold", 32'(SRAM_address), 32'd5);
        chk("stall_rgb_hold", 32'({Pixel_R, Pixel_G, Pixel_B}), 32'h112233);
        consume(18'd0, 1'b0, FRAME_PIXELS);
        chk("done_cnt_f1", 32'(done_cnt), 32'd1);
        chk("uflow_f1", 32'(Underflow), 32'd0);

        // Frame ending exactly at the top of the address space
        start_frame(18'(262144 - NWORDS));
        step();
        step();
        step();
        consume(18'(262144 - NWORDS), 1'b0, FRAME_PIXELS);
        chk("done_cnt_f2", 32'(done_cnt), 32'd2);
        chk("uflow_f2", 32'(Underflow), 32'd0);
        chk("idle_addr_f2", 32'(SRAM_address), 32'h3FFFF);

        // Frame wrapping through address 0, random consumer, stray Starts
        start_frame(18'd262072);
        consume(18'd262072, 1'b1, FRAME_PIXELS);
        chk("done_cnt_f3", 32'(done_cnt), 32'd3);
        chk("uflow_f3", 32'(Underflow), 32'd0);
        chk("idle_addr_f3", 32'(SRAM_address), 32'd71);

        // Request on an empty FIFO right after Start
        start_frame(18'd1000);
        Pixel_req = 1'b1;
        step();
        Pixel_req = 1'b0;
        chk("uflow_set", 32'(Underflow), 32'd1);
        chk("uflow_rgb_hold", 32'({Pixel_R, Pixel_G, Pixel_B}), 32'(exp_pix(18'd262072, FRAME_PIXELS - 1)));
        step();
        step();
        consume(18'd1000, 1'b0, FRAME_PIXELS);
        chk("uflow_sticky", 32'(Underflow), 32'd1);
        chk("done_cnt_f4", 32'(done_cnt), 32'd4);

        // Mid-frame reset aborts without Frame_done, then a clean restart
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("uflow_cleared", 32'(Underflow), 32'd0);
        start_frame(18'd5000);
        consume(18'd5000, 1'b1, 40);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk_reset_outputs("abort");
        for (int i = 0; i < 10; i++) step();
        chk("abort_no_done", 32'(done_cnt), 32'd4);
        chk("abort_no_stale", 32'(Pixel_valid), 32'd0);
        start_frame(18'd0);
        step();
        step();
        step();
        chk("restart_valid", 32'(Pixel_valid), 32'd1);
        chk("restart_rgb", 32'({Pixel_R, Pixel_G, Pixel_B}), 32'(exp_pix(18'd0, 0)));
        consume(18'd0, 1'b1, FRAME_PIXELS);
        chk("done_cnt_f5", 32'(done_cnt), 32'd5);
        chk("uflow_f5", 32'(Underflow), 32'd0);
        chk("we_n_end", 32'(SRAM_we_n), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
